// File: rtl/cdb_complete_arbiter_pkg.sv
// Shared types and constants for the CDB complete stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cdb_complete_arbiter_pkg;

  // Physical register tag width and result data width used across the core.
  localparam int CDB_BITS = 6;
  localparam int XLEN     = 32;

  // Tag value that marks a lane or a result as carrying nothing.
  localparam logic [CDB_BITS-1:0] CDB_NULL_TAG = '0;

  // One completion queue slot.
  typedef struct packed {
    logic [CDB_BITS-1:0] tag;
    logic [XLEN-1:0]     value;
  } cq_entry_t;

  // One CDB lane as seen by the ROB, map table and reservation stations.
  typedef struct packed {
    logic [CDB_BITS-1:0] tag;
    logic [XLEN-1:0]     value;
  } cdb_packet_t;

  // Turns a queue slot into a broadcast packet.
  function automatic cdb_packet_t to_packet(input cq_entry_t e);
    cdb_packet_t p;
    p.tag   = e.tag;
    p.value = e.value;
    return p;
  endfunction

endpackage

// File: rtl/cdb_complete_arbiter_cq_accept_select.sv
// Picks which FU results the completion queue can take this cycle.
// Latency: purely combinational.
// Backpressure: FU i is ready while fewer than 'free' real results sit at lower indices.
module cq_accept_select
  import cdb_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU   = 4,
  parameter int CQ_DEPTH = 8
) (
  input  logic [NUM_FU-1:0]                        fu_valid,
  input  logic [NUM_FU-1:0][CDB_BITS-1:0]          fu_tag,
  input  logic                                     flush,
  input  logic [$clog2(CQ_DEPTH):0]                count,
  output logic [NUM_FU-1:0]                        fu_ready,
  output logic [NUM_FU-1:0]                        wr_en,
  output logic [NUM_FU-1:0][$clog2(CQ_DEPTH)-1:0]  wr_off,
  output logic [$clog2(CQ_DEPTH):0]                num_acc
);

  localparam int PTR_W = $clog2(CQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] free;
  logic [CNT_W-1:0] pre;

  // Free slots come from the registered count only; this cycle's drain is not credited.
  assign free = CNT_W'(CQ_DEPTH) - count;

  // Prefix count of real (non-null) results below each FU decides ready and slot offset.
  always_comb begin
    pre      = '0;
    num_acc  = '0;
    fu_ready = '0;
    wr_en    = '0;
    wr_off   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = !flush && (pre < free);
      wr_off[i]   = pre[PTR_W-1:0];
      wr_en[i]    = fu_ready[i] && fu_valid[i] && (fu_tag[i] != CDB_NULL_TAG);
      if (fu_valid[i] && (fu_tag[i] != CDB_NULL_TAG)) begin
        pre = pre + CNT_W'(1);
      end
      if (wr_en[i]) begin
        num_acc = num_acc + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cdb_complete_arbiter.sv
// Complete stage: queues FU results in age order and broadcasts up to N_WAY per cycle on the CDB.
// Latency: accepted at edge t, popped onto the registered CDB at the following edge at the earliest.
// Backpressure: fu_ready per FU from registered free space; all low on flush/reset. CQ_PERF_EN adds perf counters.
module cdb_complete_arbiter
  import cdb_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU   = 4,
  parameter int N_WAY    = 2,
  parameter int CQ_DEPTH = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_FU-1:0]                  fu_valid,
  input  logic [NUM_FU-1:0][CDB_BITS-1:0]    fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]        fu_value,
  output logic [NUM_FU-1:0]                  fu_ready,
  input  logic                               branch_haz,
  output logic [N_WAY-1:0][CDB_BITS-1:0]     complete_dest_tag,
  output logic [N_WAY-1:0][XLEN-1:0]         complete_value,
  output logic [$clog2(CQ_DEPTH):0]          cq_count
`ifdef CQ_PERF_EN
  ,
  output logic [31:0]                        perf_stall_cnt,
  output logic [$clog2(CQ_DEPTH):0]          perf_max_occ
`endif
);

  localparam int PTR_W = $clog2(CQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]              head;
  logic [PTR_W-1:0]              tail;
  logic [CNT_W-1:0]              count;
  cq_entry_t                     mem [CQ_DEPTH];
  cdb_packet_t [N_WAY-1:0]       lane_q;

  logic [NUM_FU-1:0]             sel_ready;
  logic [NUM_FU-1:0]             wr_en;
  logic [NUM_FU-1:0][PTR_W-1:0]  wr_off;
  logic [CNT_W-1:0]              num_acc;
  logic [CNT_W-1:0]              drain_n;

  cq_accept_select #(
    .NUM_FU   (NUM_FU),
    .CQ_DEPTH (CQ_DEPTH)
  ) u_accept (
    .fu_valid (fu_valid),
    .fu_tag   (fu_tag),
    .flush    (branch_haz),
    .count    (count),
    .fu_ready (sel_ready),
    .wr_en    (wr_en),
    .wr_off   (wr_off),
    .num_acc  (num_acc)
  );

  // Ready is held low for as long as reset is asserted, independent of the clock.
  assign fu_ready = sel_ready & {NUM_FU{reset}};

  // Pop as many as are queued, up to one per lane.
  assign drain_n  = (count < CNT_W'(N_WAY)) ? count : CNT_W'(N_WAY);
  assign cq_count = count;

  // Slot storage carries no reset: head/tail/count define which slots are live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (wr_en[i]) begin
        mem[tail + wr_off[i]] <= '{tag: fu_tag[i], value: fu_value[i]};
      end
    end
  end

  // Pointers and occupancy: flush empties the queue, otherwise enqueue and drain together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (branch_haz) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + drain_n[PTR_W-1:0];
      tail  <= tail + num_acc[PTR_W-1:0];
      count <= count + num_acc - drain_n;
    end
  end

  // CDB lanes: oldest entry on lane 0, idle lanes forced to the null packet.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
    end else if (branch_haz) begin
      lane_q <= '0;
    end else begin
      for (int k = 0; k < N_WAY; k++) begin
        if (CNT_W'(k) < drain_n) begin
          lane_q[k] <= to_packet(mem[head + PTR_W'(k)]);
        end else begin
          lane_q[k] <= '0;
        end
      end
    end
  end

  // Unpack the lane registers onto the flat CDB ports.
  always_comb begin
    complete_dest_tag = '0;
    complete_value    = '0;
    for (int k = 0; k < N_WAY; k++) begin
      complete_dest_tag[k] = lane_q[k].tag;
      complete_value[k]    = lane_q[k].value;
    end
  end

`ifdef CQ_PERF_EN
  // Stall cycles (saturating) and peak occupancy survive flushes; only reset clears them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_max_occ   <= '0;
    end else begin
      if (!branch_haz && (|(fu_valid & ~fu_ready)) && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (count > perf_max_occ) begin
        perf_max_occ <= count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_complete_arbiter.sv
// Self-checking bench for cdb_complete_arbiter: queue-level reference model plus directed literals.
// Latency: n/a.
// Backpressure: n/a.
module tb_cdb_complete_arbiter;
  import cdb_complete_arbiter_pkg::*;

  localparam int NUM_FU   = 4;
  localparam int N_WAY    = 2;
  localparam int CQ_DEPTH = 8;
  localparam int CW       = $clog2(CQ_DEPTH) + 1;

  logic                             clock;
  logic                             reset;
  logic [NUM_FU-1:0]                fu_valid;
  logic [NUM_FU-1:0][CDB_BITS-1:0]  fu_tag;
  logic [NUM_FU-1:0][XLEN-1:0]      fu_value;
  logic [NUM_FU-1:0]                fu_ready;
  logic                             branch_haz;
  logic [N_WAY-1:0][CDB_BITS-1:0]   complete_dest_tag;
  logic [N_WAY-1:0][XLEN-1:0]       complete_value;
  logic [CW-1:0]                    cq_count;
`ifdef CQ_PERF_EN
  logic [31:0]                      perf_stall_cnt;
  logic [CW-1:0]                    perf_max_occ;
`endif

  cdb_complete_arbiter #(
    .NUM_FU   (NUM_FU),
    .N_WAY    (N_WAY),
    .CQ_DEPTH (CQ_DEPTH)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .fu_valid          (fu_valid),
    .fu_tag            (fu_tag),
    .fu_value          (fu_value),
    .fu_ready          (fu_ready),
    .branch_haz        (branch_haz),
    .complete_dest_tag (complete_dest_tag),
    .complete_value    (complete_value),
    .cq_count          (cq_count)
`ifdef CQ_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_max_occ      (perf_max_occ)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks;
  int failures;

  // Reference model: FIFO of pending results and the lanes currently on the bus.
  int          mq_tag[$];
  logic [31:0] mq_val[$];
  int          m_lt [N_WAY];
  logic [31:0] m_lv [N_WAY];
  int          seen[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  function automatic void model_clear();
    mq_tag.delete();
    mq_val.delete();
    for (int k = 0; k < N_WAY; k++) begin
      m_lt[k] = 0;
      m_lv[k] = '0;
    end
  endfunction

  task automatic clear_inputs();
    fu_valid   = '0;
    fu_tag     = '0;
    fu_value   = '0;
    branch_haz = 1'b0;
  endtask

  task automatic set_fu(input int i, input int tag, input logic [31:0] val);
    fu_valid[i] = 1'b1;
    fu_tag[i]   = CDB_BITS'(tag);
    fu_value[i] = val;
  endtask

  // One clock: compare DUT against model mid-cycle, then advance the model across the edge.
  task automatic step();
    logic [NUM_FU-1:0] er;
    int free;
    int pre;
    int d;
    #1;
    free = CQ_DEPTH - mq_tag.size();
    pre  = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      er[i] = !branch_haz && (pre < free);
      if (fu_valid[i] && fu_tag[i] != 0) pre++;
    end
    chk("fu_ready", 64'(fu_ready), 64'(er));
    chk("cq_count", 64'(cq_count), 64'(mq_tag.size()));
    for (int k = 0; k < N_WAY; k++) begin
      chk($sformatf("lane%0d_tag", k), 64'(complete_dest_tag[k]), 64'(m_lt[k]));
      chk($sformatf("lane%0d_val", k), 64'(complete_value[k]), 64'(m_lv[k]));
      if (complete_dest_tag[k] != 0) seen.push_back(int'(complete_dest_tag[k]));
    end
    @(posedge clock);
    if (branch_haz) begin
      model_clear();
    end else begin
      d = (mq_tag.size() < N_WAY) ? mq_tag.size() : N_WAY;
      for (int k = 0; k < N_WAY; k++) begin
        if (k < d) begin
          m_lt[k] = mq_tag.pop_front();
          m_lv[k] = mq_val.pop_front();
        end else begin
          m_lt[k] = 0;
          m_lv[k] = '0;
        end
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (er[i] && fu_valid[i] && fu_tag[i] != 0) begin
          mq_tag.push_back(int'(fu_tag[i]));
          mq_val.push_back(fu_value[i]);
        end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp[$];
    int stalls;
    checks   = 0;
    failures = 0;
    clear_inputs();
    model_clear();

    // Reset, then idle
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("ready_in_reset", 64'(fu_ready), 64'h0);
    chk("count_in_reset", 64'(cq_count), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("idle_ready", 64'(fu_ready), 64'hF);
    chk("idle_count", 64'(cq_count), 64'h0);
    chk("idle_tags", 64'(complete_dest_tag), 64'h0);
    @(negedge clock);

    // Ordering: three results, FU1 silent
    set_fu(0, 5, 32'h11);
    set_fu(2, 9, 32'h22);
    set_fu(3, 12, 32'h33);
    step();
    clear_inputs();
    chk("ord_count_a", 64'(cq_count), 64'd3);
    chk("ord_lane0_idle", 64'(complete_dest_tag[0]), 64'd0);
    step();
    chk("ord_c2_tag0", 64'(complete_dest_tag[0]), 64'd5);
    chk("ord_c2_val0", 64'(complete_value[0]), 64'h11);
    chk("ord_c2_tag1", 64'(complete_dest_tag[1]), 64'd9);
    chk("ord_c2_val1", 64'(complete_value[1]), 64'h22);
    chk("ord_count_b", 64'(cq_count), 64'd1);
    step();
    chk("ord_c3_tag0", 64'(complete_dest_tag[0]), 64'd12);
    chk("ord_c3_val0", 64'(complete_value[0]), 64'h33);
    chk("ord_c3_tag1", 64'(complete_dest_tag[1]), 64'd0);
    chk("ord_c3_val1", 64'(complete_value[1]), 64'h0);
    chk("ord_count_c", 64'(cq_count), 64'd0);
    step();

    // Back-pressure: occupancy 6 leaves room for two
    seen.delete();
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 30 + i, 32'h300 + i);
    step();
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 34 + i, 32'h340 + i);
    step();
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 20 + i, 32'h200 + i);
    #1;
    chk("bp_count", 64'(cq_count), 64'd6);
    chk("bp_ready", 64'(fu_ready), 64'b0011);
    step();
    clear_inputs();
    set_fu(0, 22, 32'h202);
    set_fu(1, 23, 32'h203);
    step();
    clear_inputs();
    for (int n = 0; n < 5; n++) step();
    foreach (seen[i]) if (seen[i] >= 20 && seen[i] <= 23) bp.push_back(seen[i]);
    chk("bp_num", 64'(bp.size()), 64'd4);
    for (int i = 0; i < bp.size() && i < 4; i++) chk("bp_order", 64'(bp[i]), 64'(20 + i));

    // Null tag is dropped without using a slot
    set_fu(0, 7, 32'h77);
    set_fu(1, 0, 32'hDEAD);
    #1;
    chk("zero_ready1", 64'(fu_ready[1]), 64'd1);
    step();
    clear_inputs();
    chk("zero_count", 64'(cq_count), 64'd1);
    step();
    chk("zero_tag0", 64'(complete_dest_tag[0]), 64'd7);
    chk("zero_tag1", 64'(complete_dest_tag[1]), 64'd0);
    step();

    // Flush with a queued backlog and a new result in the same cycle
    seen.delete();
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 3 + i, 32'h30 + i);
    step();
    clear_inputs();
    branch_haz = 1'b1;
    set_fu(0, 8, 32'h88);
    #1;
    chk("flush_ready", 64'(fu_ready), 64'h0);
    step();
    clear_inputs();
    chk("flush_count", 64'(cq_count), 64'd0);
    chk("flush_tags", 64'(complete_dest_tag), 64'd0);
    for (int n = 0; n < 3; n++) step();
    chk("flush_silent", 64'(seen.size()), 64'd0);

    // Wrap-around streaming, two per cycle
    seen.delete();
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      set_fu(0, 2 * c + 1, 32'h1000 + 2 * c + 1);
      set_fu(1, 2 * c + 2, 32'h1000 + 2 * c + 2);
      #1;
      if (fu_ready[1:0] != 2'b11) stalls++;
      step();
    end
    clear_inputs();
    for (int n = 0; n < 3; n++) step();
    chk("wrap_stalls", 64'(stalls), 64'd0);
    chk("wrap_num", 64'(seen.size()), 64'd40);
    for (int i = 0; i < seen.size() && i < 40; i++) chk("wrap_order", 64'(seen[i]), 64'(i + 1));

    // Randomized traffic with occasional flushes and null tags
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      for (int i = 0; i < NUM_FU; i++) begin
        if ($urandom_range(0, 99) < 65) begin
          set_fu(i, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 63)), $urandom);
        end
      end
      branch_haz = ($urandom_range(0, 49) == 0);
      step();
    end

    // Asynchronous reset with a backlog in flight
    clear_inputs();
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 40 + i, 32'h400 + i);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", 64'(cq_count), 64'd0);
    chk("arst_tags", 64'(complete_dest_tag), 64'd0);
    chk("arst_vals", 64'(complete_value), 64'd0);
    chk("arst_ready", 64'(fu_ready), 64'h0);
    model_clear();
    clear_inputs();
    @(negedge clock);
    reset = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
